// File: rtl/translator_reassemble_pkg.sv
// ============================================================================
// Module  : translator_reassemble_pkg
// Brief   : Shared translator beat-field constants, type codes and FSM states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package translator_reassemble_pkg;

   localparam int PKTID_LSB  = 0;
   localparam int PKTID_W    = 32;
   localparam int FOLLOW_BIT = 32;
   localparam int TYPE_BIT   = 33;
   localparam int SLICE_LSB  = 64;

   localparam logic TYPE_HDR = 1'b0;
   localparam logic TYPE_PAY = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_PAY = 3'd1,
      ST_PAY      = 3'd2,
      ST_DROP     = 3'd3,
      ST_OUT      = 3'd4
   } state_e;

   // Payload beats needed to fill the word above the header slice (at least one).
   function automatic int calc_pay_beats(input int slice_w, input int width_out);
      int n;
      n = (width_out - 1) / slice_w;
      if (n < 1) n = 1;
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/avalonST.sv
// ============================================================================
// Module  : avalonST
// Brief   : Avalon-ST packet interface (valid/ready, sop/eop, empty, error).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface avalonST #(
   parameter int DATA_WIDTH = 512
);
   localparam int EMPTY_W = $clog2(DATA_WIDTH / 8);

   logic                  valid;
   logic                  ready;
   logic                  sop;
   logic                  eop;
   logic [EMPTY_W-1:0]    empty;
   logic                  error;
   logic [DATA_WIDTH-1:0] data;

   modport sink   (input valid, sop, eop, empty, error, data, output ready);
   modport source (output valid, sop, eop, empty, error, data, input ready);
endinterface

`default_nettype wire

// File: rtl/translator_slice_buf.sv
// ============================================================================
// Module  : translator_slice_buf
// Brief   : Word buffer with payload beat index, slice write decode and clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module translator_slice_buf
   import translator_reassemble_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int WIDTH_OUT  = 600
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clear_i,
   input  logic                        hdr_wr_i,
   input  logic                        pay_wr_i,
   input  logic [DATA_WIDTH-SLICE_LSB-1:0] slice_i,
   output logic [WIDTH_OUT-1:0]        word_o
);
   localparam int SLICE_W   = DATA_WIDTH - SLICE_LSB;
   localparam int PAY_BEATS = calc_pay_beats(SLICE_W, WIDTH_OUT);
   localparam int IDX_W     = $clog2(PAY_BEATS + 1);

   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [WIDTH_OUT-1:0] word_q, word_d;

   // Segment 0 is the header slice; segment j holds payload beat j-1, clipped at WIDTH_OUT.
   for (genvar j = 0; j <= PAY_BEATS; j++) begin : g_seg
      localparam int LO = SLICE_W * j;
      localparam int HI = (SLICE_W * (j + 1) < WIDTH_OUT) ? SLICE_W * (j + 1) : WIDTH_OUT;
      if (LO < WIDTH_OUT) begin : g_live
         logic we;
         if (j == 0) begin : g_hdr
            assign we = hdr_wr_i;
         end else begin : g_pay
            assign we = pay_wr_i && (idx_q == IDX_W'(j - 1));
         end
         assign word_d[HI-1:LO] = clear_i ? '0 : (we ? slice_i[HI-LO-1:0] : word_q[HI-1:LO]);
      end
   end

   // Index saturates at PAY_BEATS so surplus beats match no segment.
   always_comb begin
      idx_d = idx_q;
      if (clear_i)
         idx_d = '0;
      else if (pay_wr_i && (idx_q < IDX_W'(PAY_BEATS)))
         idx_d = idx_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

   assign word_o = word_q;

endmodule

`default_nettype wire

// File: rtl/translator_reassemble.sv
// ============================================================================
// Module  : translator_reassemble
// Brief   : Rebuilds a wide word from NoC header + payload Avalon-ST packets.
//           Optional macro TRANSLATOR_REASSEMBLE_PKTID_CHECK_EN adds pkt_id check.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module translator_reassemble
   import translator_reassemble_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int WIDTH_OUT  = 600,
   parameter int NUM_VC     = 2,
   parameter int NOC_RADIX  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   avalonST.sink                in,
   output logic [WIDTH_OUT-1:0] o_data_out,
   output logic                 o_valid_out,
   input  logic                 i_ready_in,
   output logic [31:0]          o_pktid_out,
   output logic                 o_payload_flag,
   output logic                 o_error_out,
   output logic [15:0]          o_drop_count
);
   state_e        state_q, state_d;
   logic [31:0]   pktid_q, pktid_d;
   logic          flag_q, flag_d;
   logic          err_q, err_d;
   logic [15:0]   drop_q, drop_d;
   logic [1:0]    drop_inc;
   logic [16:0]   drop_sum;
   logic          hdr_wr, pay_wr, buf_clear;
   logic          acc, pid_mismatch;
   logic [31:0]   beat_pid;
   logic          unused_bits;

   assign in.ready = (state_q != ST_OUT);
   assign acc      = in.valid && in.ready;
   assign beat_pid = in.data[PKTID_LSB +: PKTID_W];

`ifdef TRANSLATOR_REASSEMBLE_PKTID_CHECK_EN
   assign pid_mismatch = (beat_pid != pktid_q);
`else
   assign pid_mismatch = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      pktid_d  = pktid_q;
      flag_d   = flag_q;
      err_d    = err_q;
      drop_inc = 2'd0;
      hdr_wr   = 1'b0;
      pay_wr   = 1'b0;
      case (state_q)
         ST_IDLE, ST_WAIT_PAY: begin
            if (acc) begin
               if (!in.sop) begin
                  drop_inc = 2'd1;
               end else if (in.data[TYPE_BIT] == TYPE_PAY) begin
                  if (state_q == ST_WAIT_PAY) begin
                     pay_wr  = 1'b1;
                     flag_d  = 1'b1;
                     err_d   = err_q | in.error | pid_mismatch;
                     state_d = in.eop ? ST_OUT : ST_PAY;
                  end else begin
                     drop_inc = 2'd1;
                     state_d  = in.eop ? ST_IDLE : ST_DROP;
                  end
               end else begin
                  // A header in WAIT_PAY abandons the pending word, then acts as in IDLE.
                  drop_inc = (state_q == ST_WAIT_PAY) ? 2'd1 : 2'd0;
                  if (!in.eop) begin
                     drop_inc = drop_inc + 2'd1;
                     state_d  = ST_DROP;
                  end else begin
                     hdr_wr  = 1'b1;
                     pktid_d = beat_pid;
                     flag_d  = 1'b0;
                     err_d   = in.error;
                     state_d = in.data[FOLLOW_BIT] ? ST_WAIT_PAY : ST_OUT;
                  end
               end
            end
         end
         ST_PAY: begin
            if (acc) begin
               pay_wr = 1'b1;
               err_d  = err_q | in.error | in.sop;
               if (in.eop) state_d = ST_OUT;
            end
         end
         ST_DROP: begin
            if (acc && in.eop) state_d = ST_IDLE;
         end
         ST_OUT: begin
            if (i_ready_in) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign buf_clear = (state_d == ST_IDLE);
   assign drop_sum  = {1'b0, drop_q} + 17'(drop_inc);
   assign drop_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pktid_q <= '0;
         flag_q  <= 1'b0;
         err_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pktid_q <= pktid_d;
         flag_q  <= flag_d;
         err_q   <= err_d;
         drop_q  <= drop_d;
      end
   end

   translator_slice_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .WIDTH_OUT  (WIDTH_OUT)
   ) u_slice_buf (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (buf_clear),
      .hdr_wr_i (hdr_wr),
      .pay_wr_i (pay_wr),
      .slice_i  (in.data[DATA_WIDTH-1:SLICE_LSB]),
      .word_o   (o_data_out)
   );

   assign o_valid_out    = (state_q == ST_OUT);
   assign o_pktid_out    = pktid_q;
   assign o_payload_flag = flag_q;
   assign o_error_out    = err_q;
   assign o_drop_count   = drop_q;

   assign unused_bits = ^{in.empty, in.data[SLICE_LSB-1:TYPE_BIT+1], NUM_VC[0], NOC_RADIX[0]};

endmodule

`default_nettype wire

// File: tb/tb_translator_reassemble.sv
// ============================================================================
// Module  : tb_translator_reassemble
// Brief   : Scoreboard bench for translator_reassemble with directed packets.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_translator_reassemble;
   localparam int DW = 512;
   localparam int WO = 600;
   localparam int SW = 448;

`ifdef TRANSLATOR_REASSEMBLE_PKTID_CHECK_EN
   localparam logic MISMATCH_ERR = 1'b1;
`else
   localparam logic MISMATCH_ERR = 1'b0;
`endif

   typedef struct {
      logic [WO-1:0] d;
      logic [31:0]   pid;
      logic          f;
      logic          e;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          i_ready_in = 1'b1;
   logic [WO-1:0] o_data_out;
   logic          o_valid_out;
   logic [31:0]   o_pktid_out;
   logic          o_payload_flag;
   logic          o_error_out;
   logic [15:0]   o_drop_count;

   int   checks = 0;
   int   failures = 0;
   exp_t q[$];
   exp_t mon_e;

   avalonST #(.DATA_WIDTH(DW)) s_if ();

   translator_reassemble #(
      .DATA_WIDTH (DW),
      .WIDTH_OUT  (WO),
      .NUM_VC     (2),
      .NOC_RADIX  (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .in             (s_if),
      .o_data_out     (o_data_out),
      .o_valid_out    (o_valid_out),
      .i_ready_in     (i_ready_in),
      .o_pktid_out    (o_pktid_out),
      .o_payload_flag (o_payload_flag),
      .o_error_out    (o_error_out),
      .o_drop_count   (o_drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input logic [31:0] pid, input logic typ,
                                        input logic fol, input logic [SW-1:0] sl);
      return {sl, 30'd0, typ, fol, pid};
   endfunction

   function automatic exp_t ex(input logic [WO-1:0] d, input logic [31:0] pid,
                               input logic f, input logic e);
      exp_t r;
      r.d = d; r.pid = pid; r.f = f; r.e = e;
      return r;
   endfunction

   // Drives one beat and returns #1 after the edge that accepted it.
   task automatic beat(input logic sop, input logic eop, input logic err, input logic [DW-1:0] d);
      int n = 0;
      s_if.valid = 1'b1; s_if.sop = sop; s_if.eop = eop; s_if.error = err; s_if.data = d;
      @(negedge clk);
      while (!s_if.ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++; failures++;
         $display("FAIL beat_accept_timeout actual=ready_low required=ready_high");
      end
      @(posedge clk); #1;
      s_if.valid = 1'b0; s_if.sop = 1'b0; s_if.eop = 1'b0; s_if.error = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while (q.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk(nm, 640'(q.size()), 640'd0);
   endtask

   always @(negedge clk) begin
      if (!reset && o_valid_out && i_ready_in) begin
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_word actual=pktid_%h required=no_word", o_pktid_out);
         end else begin
            mon_e = q.pop_front();
            chk("word_data",  640'(o_data_out),     640'(mon_e.d));
            chk("word_pktid", 640'(o_pktid_out),    640'(mon_e.pid));
            chk("word_flag",  640'(o_payload_flag), 640'(mon_e.f));
            chk("word_error", 640'(o_error_out),    640'(mon_e.e));
         end
      end
   end

   initial begin
      logic [SW-1:0] ones, s0, s1, p0, p1, p2;
      logic [WO-1:0] hold_exp;
      ones = '1;
      s0 = {14{32'h12345678}};
      s1 = {14{32'h0F1E2D3C}};
      p0 = {14{32'hABCDEF01}};
      p1 = {14{32'h55AA33CC}};
      p2 = {14{32'hDEADBEEF}};
      s_if.valid = 1'b0; s_if.sop = 1'b0; s_if.eop = 1'b0; s_if.error = 1'b0;
      s_if.empty = '0; s_if.data = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 640'(o_valid_out),    640'd0);
      chk("rst_data",  640'(o_data_out),     640'd0);
      chk("rst_pktid", 640'(o_pktid_out),    640'd0);
      chk("rst_flag",  640'(o_payload_flag), 640'd0);
      chk("rst_error", 640'(o_error_out),    640'd0);
      chk("rst_drop",  640'(o_drop_count),   640'd0);
      chk("rst_ready", 640'(s_if.ready),     640'd1);
      reset = 1'b0;
      @(posedge clk); #1;

      // Header only
      q.push_back(ex({152'd0, ones}, 32'h11, 1'b0, 1'b0));
      beat(1, 1, 0, mk(32'h11, 1'b0, 1'b0, ones));
      chk("hdr_latency_valid", 640'(o_valid_out), 640'd1);
      wait_drain("hdr_drain");

      // Header + payload with consumer back-pressure
      i_ready_in = 1'b0;
      hold_exp = {p0[151:0], s0};
      q.push_back(ex(hold_exp, 32'h22, 1'b1, 1'b0));
      beat(1, 1, 0, mk(32'h22, 1'b0, 1'b1, s0));
      beat(1, 1, 0, mk(32'h22, 1'b1, 1'b0, p0));
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 640'(o_valid_out), 640'd1);
         chk("hold_ready", 640'(s_if.ready),  640'd0);
         chk("hold_data",  640'(o_data_out),  640'(hold_exp));
         chk("hold_pktid", 640'(o_pktid_out), 640'h22);
         @(posedge clk); #1;
      end
      i_ready_in = 1'b1;
      wait_drain("pay_drain");

      // Surplus payload beats discarded, in.error on a middle beat
      q.push_back(ex({p0[151:0], s1}, 32'h55, 1'b1, 1'b1));
      beat(1, 1, 0, mk(32'h55, 1'b0, 1'b1, s1));
      beat(1, 0, 0, mk(32'h55, 1'b1, 1'b0, p0));
      beat(0, 0, 1, {p1, 64'd0});
      beat(0, 1, 0, {p2, 64'd0});
      wait_drain("surplus_drain");

      // Sop seen inside PAY
      q.push_back(ex({p0[151:0], s1}, 32'h66, 1'b1, 1'b1));
      beat(1, 1, 0, mk(32'h66, 1'b0, 1'b1, s1));
      beat(1, 0, 0, mk(32'h66, 1'b1, 1'b0, p0));
      beat(1, 1, 0, mk(32'h67, 1'b1, 1'b0, p1));
      wait_drain("sop_in_pay_drain");

      // Orphan payload, then a normal header
      beat(1, 0, 0, mk(32'h70, 1'b1, 1'b0, p0));
      beat(0, 0, 0, {p1, 64'd0});
      beat(0, 1, 0, {p2, 64'd0});
      chk("orphan_drop", 640'(o_drop_count), 640'd1);
      chk("orphan_no_valid", 640'(o_valid_out), 640'd0);
      q.push_back(ex({152'd0, s1}, 32'h77, 1'b0, 1'b0));
      beat(1, 1, 0, mk(32'h77, 1'b0, 1'b0, s1));
      wait_drain("after_orphan_drain");

      // New header while waiting for payload
      q.push_back(ex({152'd0, s1}, 32'h33, 1'b0, 1'b0));
      beat(1, 1, 0, mk(32'h30, 1'b0, 1'b1, s0));
      beat(1, 1, 0, mk(32'h33, 1'b0, 1'b0, s1));
      chk("rehdr_drop", 640'(o_drop_count), 640'd2);
      wait_drain("rehdr_drain");

      // Stray non-sop beat in IDLE
      beat(0, 1, 0, {p0, 64'd0});
      chk("stray_drop", 640'(o_drop_count), 640'd3);

      // pkt_id mismatch between header and payload
      q.push_back(ex({p0[151:0], s0}, 32'h44, 1'b1, MISMATCH_ERR));
      beat(1, 1, 0, mk(32'h44, 1'b0, 1'b1, s0));
      beat(1, 1, 0, mk(32'h45, 1'b1, 1'b0, p0));
      wait_drain("pid_drain");

      // Reset while in PAY
      beat(1, 1, 0, mk(32'h88, 1'b0, 1'b1, s0));
      beat(1, 0, 0, mk(32'h88, 1'b1, 1'b0, p0));
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_valid", 640'(o_valid_out),    640'd0);
      chk("midrst_data",  640'(o_data_out),     640'd0);
      chk("midrst_pktid", 640'(o_pktid_out),    640'd0);
      chk("midrst_flag",  640'(o_payload_flag), 640'd0);
      chk("midrst_error", 640'(o_error_out),    640'd0);
      chk("midrst_drop",  640'(o_drop_count),   640'd0);
      chk("midrst_ready", 640'(s_if.ready),     640'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      beat(0, 1, 0, {p1, 64'd0});
      chk("postrst_drop", 640'(o_drop_count), 640'd1);
      q.push_back(ex({p1[151:0], s1}, 32'h99, 1'b1, 1'b0));
      beat(1, 1, 0, mk(32'h99, 1'b0, 1'b1, s1));
      beat(1, 1, 0, mk(32'h99, 1'b1, 1'b0, p1));
      wait_drain("postrst_drain");

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/translator_reassemble.md
# translator_reassemble

Receive-side counterpart of the NoC packet translators. It accepts the Avalon-ST header packet and optional payload packet that the transmit side emits for each wide word. It reassembles them into one WIDTH_OUT-bit word, restores pkt_id and the payload flag, and hands the word to the consumer over a valid/ready handshake. It sits between the NoC egress port and the downstream wide-word consumer.

## Interface
Parameters:
- DATA_WIDTH, 512, flit/beat width of the Avalon-ST input; must be ≥ 128.
- WIDTH_OUT, 600, width of the reassembled word.
- NUM_VC, 2, NoC virtual channels; carried for interface uniformity, no logic depends on it.
- NOC_RADIX, 16, NoC radix; carried for interface uniformity, no logic depends on it.
- Derived localparams:
  - SLICE_W = DATA_WIDTH-64.
  - PAY_BEATS = max(1, ceil((WIDTH_OUT-SLICE_W)/SLICE_W)).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in  avalonST.sink  DATA_WIDTH  NoC-side packet input (valid, ready, sop, eop, empty, error, data).
- o_data_out  out  WIDTH_OUT  reassembled word.
- o_valid_out  out  1  word valid.
- i_ready_in  in  1  consumer ready.
- o_pktid_out  out  32  pkt_id of the presented word.
- o_payload_flag  out  1  word carried a payload packet.
- o_error_out  out  1  word is suspect; see Operation.
- o_drop_count  out  16  saturating count of discarded packets.

## Operation
Beat format:
- Sop beat: data[31:0]=pkt_id, data[33]=type (0 header, 1 payload).
- Header sop beat also uses data[32]=payload_follows.
- Every beat: data[DATA_WIDTH-1:64] = slice; data[63:34] ignored.

Header packet rules:
- Exactly one beat (sop=eop=1).
- Slice goes to word[SLICE_W-1:0].
- If payload_follows=0: upper word bits are zero and the word is complete.

Payload packet rules:
- Beat k (k=0..) slice goes to word[SLICE_W*(k+1)+:SLICE_W].
- Bits beyond WIDTH_OUT are discarded. Beats beyond PAY_BEATS are accepted and discarded.
- Early eop leaves the remaining word bits zero.

States: IDLE, WAIT_PAY, PAY, DROP, OUT. Transitions on accepted beats (in.valid && in.ready):
- IDLE, header sop+eop, flag=0: → OUT.
- IDLE, header sop+eop, flag=1: → WAIT_PAY.
- IDLE, header sop without eop: malformed; drop+1; → DROP.
- IDLE, payload sop: orphan; drop+1; → DROP, or stay IDLE if eop.
- IDLE or WAIT_PAY, non-sop beat: discarded, drop+1.
- WAIT_PAY, payload sop: → PAY, or → OUT if eop.
- WAIT_PAY, header sop: pending word abandoned, drop+1; the beat is processed as in IDLE.
- PAY, any beat: slice stored; eop → OUT. A sop seen in PAY is stored as data and sets error.
- DROP: eop → IDLE.
- OUT: o_valid_out=1; on i_ready_in → IDLE.

Error and counter rules:
- o_error_out is set if any beat of the word had in.error=1, or on a pkt_id mismatch (see Configuration), or on a sop seen in PAY.
- o_drop_count saturates at 16'hFFFF.

## Timing
- in.ready = (state != OUT). Combinational, registered state only.
- Latency: o_valid_out rises the cycle after the completing eop beat is accepted.
- Output handshake:
  - o_data_out, o_pktid_out, o_payload_flag and o_error_out are stable while o_valid_out && !i_ready_in.
  - Completion is the cycle o_valid_out && i_ready_in. in.ready rises the following cycle, giving one bubble per word.
- Reset:
  - State → IDLE; o_valid_out=0; o_data_out=0; o_pktid_out=0; o_payload_flag=0; o_error_out=0; o_drop_count=0.
  - Reset mid-packet discards the partial word without counting. Beats arriving after reset of a packet already in flight are handled by the IDLE rules.
- The word buffer is cleared to zero on every entry to IDLE so that zero-fill holds.

## Configuration
- TRANSLATOR_REASSEMBLE_PKTID_CHECK_EN defined:
  - The payload sop pkt_id is compared with the stored header pkt_id.
  - A mismatch is still reassembled and sets o_error_out.
  - o_pktid_out reports the header pkt_id.
- Undefined: no comparison and no comparator logic. o_error_out comes only from in.error and from a sop seen in PAY.

## Structure
- The shared translator package holds:
  - Beat field constants: PKTID_LSB=0, PKTID_W=32, FOLLOW_BIT=32, TYPE_BIT=33, SLICE_LSB=64.
  - The type encodings.
  - The state enum typedef.
- Transmit translators import the same package.
- One sub-module is natural: translator_slice_buf, the word buffer with beat index, slice write-enable decode, clear, and bound check.

## Test plan
- Header only: pkt_id=0x11, flag=0, slice=all-ones → word[447:0] ones, word[599:448]=0, o_pktid_out=0x11, o_payload_flag=0, valid 1 cycle after eop.
- Header+payload: pkt_id=0x22, payload slice=0xABCD… → word[599:448]=slice[151:0], o_payload_flag=1; hold i_ready_in=0 for 5 cycles → outputs stable and in.ready=0 throughout.
- Orphan payload (type=1, 3 beats) in IDLE → no output, o_drop_count=1; the header that follows reassembles normally.
- WAIT_PAY receives a new header (pkt_id=0x33, flag=0) → drop_count+1, word 0x33 emitted.
- Macro defined, payload pkt_id=0x45 after header 0x44 → o_error_out=1, o_pktid_out=0x44. Macro undefined → o_error_out=0.
- Reset asserted during PAY → all outputs 0 the next cycle, state IDLE; the next full packet pair reassembles correctly.
